// File: rtl/fetch_decode_seq_if.sv
// Memory-read and decoded-output bundle for fetch_decode_seq.
// The master side is the fetch engine; the slave side is the memory plus consumer.
interface fetch_decode_seq_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [31:0]       mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_fmt;
  logic [ADDR_W-1:0] out_addr;
  logic [5:0]        out_op;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [15:0]       out_imm;
  logic [25:0]       out_target;

  modport master (
    output mem_addr, mem_read,
    input  mem_data,
    output out_valid, out_fmt, out_addr, out_op, out_rs, out_rt, out_rd,
    output out_shamt, out_funct, out_imm, out_target,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_read,
    output mem_data,
    input  out_valid, out_fmt, out_addr, out_op, out_rs, out_rt, out_rd,
    input  out_shamt, out_funct, out_imm, out_target,
    output out_ready
  );
endinterface

// File: rtl/fetch_decode_seq.sv
// Sequential fetch-and-decode engine: walks `count` words from BASE in steps of STRIDE,
// splits each MIPS-style word into R/I/J fields and offers it on a valid/ready port.
module fetch_decode_seq #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(128),
  parameter int unsigned       STRIDE   = 4,
  parameter int unsigned       MEM_LAT  = 1,
  parameter int unsigned       CNT_W    = 8,
  parameter bit                JAL_IS_J = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  fetch_decode_seq_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  // WAIT lasts MEM_LAT cycles; data is sampled in the one where the counter hits this.
  localparam logic [1:0] LastWait = (MEM_LAT == 0) ? 2'd0 : 2'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [1:0]        wait_q, wait_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        fmt_q, fmt_d;
  logic              done_q, done_d;
  logic              sample;
  logic              reading;

  // 0 = R, 1 = I, 2 = J; JAL (op 3) joins J only when JAL_IS_J is set.
  function automatic logic [1:0] classify(input logic [5:0] op);
    if (op == 6'd0) return 2'd0;
    if (op == 6'd2 || (JAL_IS_J && op == 6'd3)) return 2'd2;
    return 2'd1;
  endfunction

  // Sequencer: state, pc, remaining-word count and the done pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            pc_d    = BASE;
            rem_d   = count_i;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (MEM_LAT == 0) begin
          sample  = 1'b1;
          state_d = StHold;
        end else begin
          wait_d  = 2'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == LastWait) begin
          sample  = 1'b1;
          state_d = StHold;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          pc_d  = pc_q + ADDR_W'(STRIDE);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture path: the fetched word and its address are frozen until the next sample.
  always_comb begin
    word_d = word_q;
    addr_d = addr_q;
    fmt_d  = fmt_q;
    if (sample) begin
      word_d = bus.mem_data;
      addr_d = pc_q;
      fmt_d  = classify(bus.mem_data[31:26]);
    end
  end

  // State registers with synchronous reset; reset aborts a run without a done pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= 2'd0;
      word_q  <= '0;
      fmt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      fmt_q   <= fmt_d;
      done_q  <= done_d;
    end
  end

  assign reading = (state_q == StIssue) || (state_q == StWait);

  assign busy_o         = state_q != StIdle;
  assign done_o         = done_q;
  assign bus.mem_read   = reading;
  assign bus.mem_addr   = reading ? pc_q : '0;
  assign bus.out_valid  = state_q == StHold;
  assign bus.out_fmt    = fmt_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_op     = word_q[31:26];
  assign bus.out_rs     = word_q[25:21];
  assign bus.out_rt     = word_q[20:16];
  assign bus.out_rd     = word_q[15:11];
  assign bus.out_shamt  = word_q[10:6];
  assign bus.out_funct  = word_q[5:0];
  assign bus.out_imm    = word_q[15:0];
  assign bus.out_target = word_q[25:0];

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Four engines (different latency/base/JAL settings) run side by side against a
// cycle-timing and memory-contents model; literal decode values pin that model.
module tb_fetch_decode_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] count = 8'd0;
  bit         rnd_ready = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  localparam logic [31:0] Garbage = 32'hDEAD_BEEF;

  logic [31:0] mem_w [16];
  logic [3:0]  busy_v, done_v, mread_v;
  int          n_acc [4];
  int          n_done [4];
  logic [31:0] acc_addr [4][128];
  logic [31:0] acc_word [4][128];
  logic [15:0] acc_imm  [4][128];
  logic [25:0] acc_tgt  [4][128];
  logic [1:0]  acc_fmt  [4][128];
  int          acc_cyc  [4][128];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_fmt(input logic [5:0] op, input bit jal);
    if (op == 6'd0) return 2'd0;
    if (op == 6'd2 || (jal && op == 6'd3)) return 2'd2;
    return 2'd1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 2 : 3;
    localparam int unsigned HI  = (LAT == 0) ? 0 : LAT - 1;
    localparam logic [31:0] BS  = (g == 2) ? 32'hFFFF_FFFC : 32'd128;
    localparam bit          JAL = (g == 0) || (g == 2);

    fetch_decode_seq_if #(.ADDR_W(32)) bus ();
    logic busy, done;

    fetch_decode_seq #(
      .ADDR_W  (32),
      .BASE    (BS),
      .STRIDE  (4),
      .MEM_LAT (LAT),
      .CNT_W   (8),
      .JAL_IS_J(JAL)
    ) u_dut (
      .clk_i  (clk),
      .reset_i(reset),
      .start_i(start),
      .count_i(count),
      .busy_o (busy),
      .done_o (done),
      .bus    (bus)
    );

    assign busy_v[g]     = busy;
    assign done_v[g]     = done;
    assign mread_v[g]    = bus.mem_read;
    assign bus.out_ready = ready;

    // Memory: data is correct only exactly LAT cycles after a read request.
    logic        hist_rd [4] = '{default: 1'b0};
    logic [31:0] hist_ad [4] = '{default: 32'd0};
    always @(posedge clk) begin
      hist_rd[0] <= bus.mem_read;
      hist_ad[0] <= bus.mem_addr;
      for (int i = 1; i < 4; i++) begin
        hist_rd[i] <= hist_rd[i-1];
        hist_ad[i] <= hist_ad[i-1];
      end
    end
    always_comb begin
      if (LAT == 0) bus.mem_data = bus.mem_read ? mem_w[bus.mem_addr[5:2]] : Garbage;
      else          bus.mem_data = hist_rd[HI] ? mem_w[hist_ad[HI][5:2]] : Garbage;
    end

    // Model: per-word timing from issue cycle, expected word from the memory table.
    bit          armed = 1'b0, active = 1'b0, zchk = 1'b0;
    bit          e_valid = 1'b0, e_mread = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    int          rem = 0, t_iss = 0;
    logic [31:0] addr = 32'd0;
    logic [31:0] w;
    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("g%0d valid", g), 128'(bus.out_valid), 128'(e_valid));
        chk($sformatf("g%0d mem_read", g), 128'(bus.mem_read), 128'(e_mread));
        chk($sformatf("g%0d busy", g), 128'(busy), 128'(e_busy));
        chk($sformatf("g%0d done", g), 128'(done), 128'(e_done));
        if (e_mread) chk($sformatf("g%0d mem_addr", g), 128'(bus.mem_addr), 128'(addr));
        if (e_valid) begin
          w = mem_w[addr[5:2]];
          chk($sformatf("g%0d out_addr", g), 128'(bus.out_addr), 128'(addr));
          chk($sformatf("g%0d out_fmt", g), 128'(bus.out_fmt), 128'(exp_fmt(w[31:26], JAL)));
          chk($sformatf("g%0d fields", g),
              128'({bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                    bus.out_funct, bus.out_imm, bus.out_target}),
              128'({w, w[15:0], w[25:0]}));
        end
        if (zchk) begin
          chk($sformatf("g%0d reset fields", g),
              128'({bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                    bus.out_funct, bus.out_imm, bus.out_target}), 128'(0));
          chk($sformatf("g%0d reset addr/fmt", g),
              128'({bus.out_addr, bus.out_fmt, bus.mem_addr}), 128'(0));
        end
        if (done) n_done[g]++;
      end

      zchk   = 1'b0;
      e_done = 1'b0;
      if (reset) begin
        armed  = 1'b1;
        active = 1'b0;
        zchk   = 1'b1;
      end else if (armed) begin
        if (!active) begin
          if (start) begin
            if (count == 8'd0) begin
              e_done = 1'b1;
            end else begin
              active = 1'b1;
              rem    = int'(count);
              addr   = BS;
              t_iss  = cyc + 1;
            end
          end
        end else if (e_valid && ready) begin
          if (n_acc[g] < 128) begin
            acc_addr[g][n_acc[g]] = bus.out_addr;
            acc_word[g][n_acc[g]] = {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd,
                                     bus.out_shamt, bus.out_funct};
            acc_imm[g][n_acc[g]]  = bus.out_imm;
            acc_tgt[g][n_acc[g]]  = bus.out_target;
            acc_fmt[g][n_acc[g]]  = bus.out_fmt;
            acc_cyc[g][n_acc[g]]  = cyc;
          end
          n_acc[g]++;
          rem--;
          addr = addr + 32'd4;
          if (rem == 0) begin
            active = 1'b0;
            e_done = 1'b1;
          end else begin
            t_iss = cyc + 1;
          end
        end
      end
      e_busy  = active;
      e_mread = active && (cyc + 1 >= t_iss) && (cyc + 1 <= t_iss + int'(LAT));
      e_valid = active && (cyc + 1 > t_iss + int'(LAT));
    end
  end

  // Random back-pressure: ready high about 30% of cycles when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy_v == 4'b0) break;
    end
    if (i >= 2000) chk("idle timeout", 128'(busy_v), 128'(0));
    @(posedge clk);
  endtask

  task automatic run(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    count = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
  endtask

  int b[4], d[4], b1, n, i;
  logic [31:0] wr;

  initial begin
    mem_w[0] = 32'h014B_4820;
    mem_w[1] = 32'h8D28_0004;
    mem_w[2] = 32'h0800_0020;
    mem_w[3] = 32'h0C00_0020;
    for (int k = 4; k < 16; k++) begin
      wr = $urandom;
      case ($urandom_range(0, 3))
        0: wr[31:26] = 6'd0;
        1: wr[31:26] = 6'd2;
        2: wr[31:26] = 6'd3;
        default: ;
      endcase
      mem_w[k] = wr;
    end

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Run 1: count 11, no stalls.
    for (int g = 0; g < 4; g++) begin b[g] = n_acc[g]; d[g] = n_done[g]; end
    run(11);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("g%0d run1 accepts", g), 128'(n_acc[g] - b[g]), 128'(11));
      chk($sformatf("g%0d run1 dones", g), 128'(n_done[g] - d[g]), 128'(1));
    end
    for (int k = 0; k < 11; k++)
      chk($sformatf("g0 addr %0d", k), 128'(acc_addr[0][b[0]+k]), 128'(128 + 4 * k));
    for (int k = 1; k < 11; k++)
      chk($sformatf("g0 period %0d", k), 128'(acc_cyc[0][b[0]+k] - acc_cyc[0][b[0]+k-1]),
          128'(3));
    chk("g1 period", 128'(acc_cyc[1][b[1]+1] - acc_cyc[1][b[1]]), 128'(2));
    chk("g2 period", 128'(acc_cyc[2][b[2]+1] - acc_cyc[2][b[2]]), 128'(4));
    chk("g3 period", 128'(acc_cyc[3][b[3]+1] - acc_cyc[3][b[3]]), 128'(5));
    // Hand-decoded literals.
    wr = acc_word[0][b[0]];
    chk("R fmt", 128'(acc_fmt[0][b[0]]), 128'(0));
    chk("R rs/rt/rd/funct", 128'({wr[25:21], wr[20:16], wr[15:11], wr[5:0]}),
        128'({5'd10, 5'd11, 5'd9, 6'h20}));
    wr = acc_word[0][b[0]+1];
    chk("I fmt", 128'(acc_fmt[0][b[0]+1]), 128'(1));
    chk("I op/rs/rt/imm", 128'({wr[31:26], wr[25:21], wr[20:16], acc_imm[0][b[0]+1]}),
        128'({6'd35, 5'd9, 5'd8, 16'd4}));
    chk("J fmt", 128'(acc_fmt[0][b[0]+2]), 128'(2));
    chk("J target", 128'(acc_tgt[0][b[0]+2]), 128'(26'h20));
    chk("JAL as J", 128'(acc_fmt[0][b[0]+3]), 128'(2));
    chk("JAL as I", 128'(acc_fmt[1][b[1]+3]), 128'(1));
    chk("wrap addr0", 128'(acc_addr[2][b[2]]), 128'(32'hFFFF_FFFC));
    chk("wrap addr1", 128'(acc_addr[2][b[2]+1]), 128'(32'h0000_0000));

    // Run 2: same count under random back-pressure; sequence must match run 1.
    b1 = b[0];
    for (int g = 0; g < 4; g++) b[g] = n_acc[g];
    rnd_ready = 1'b1;
    run(11);
    for (int g = 0; g < 4; g++)
      chk($sformatf("g%0d run2 accepts", g), 128'(n_acc[g] - b[g]), 128'(11));
    for (int k = 0; k < 11; k++)
      chk($sformatf("g0 stall seq %0d", k), 128'({acc_addr[0][b[0]+k], acc_word[0][b[0]+k]}),
          128'({acc_addr[0][b1+k], acc_word[0][b1+k]}));

    // count = 0: done pulse, no fetch.
    for (int g = 0; g < 4; g++) begin b[g] = n_acc[g]; d[g] = n_done[g]; end
    run(0);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("g%0d zero dones", g), 128'(n_done[g] - d[g]), 128'(1));
      chk($sformatf("g%0d zero accepts", g), 128'(n_acc[g] - b[g]), 128'(0));
    end

    // Random short runs under back-pressure.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int g = 0; g < 4; g++) b[g] = n_acc[g];
      run(n);
      for (int g = 0; g < 4; g++)
        chk($sformatf("g%0d rand run%0d accepts", g, r), 128'(n_acc[g] - b[g]), 128'(n));
    end

    // Reset during WAIT of the third word of g0.
    rnd_ready = 1'b0;
    b[0] = n_acc[0];
    d[0] = n_done[0];
    @(posedge clk);
    #1;
    start = 1'b1;
    count = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_acc[0] - b[0] >= 2 && mread_v[0]) break;
    end
    if (i >= 200) chk("third issue timeout", 128'(n_acc[0] - b[0]), 128'(2));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 128'(busy_v), 128'(0));
    chk("reset done", 128'(done_v), 128'(0));
    @(posedge clk);
    chk("reset accepts", 128'(n_acc[0] - b[0]), 128'(2));
    chk("reset no done", 128'(n_done[0] - d[0]), 128'(0));
    b[0] = n_acc[0];
    run(2);
    chk("restart addr0", 128'(acc_addr[0][b[0]]), 128'(128));
    chk("restart addr1", 128'(acc_addr[0][b[0]+1]), 128'(132));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_seq.md
# fetch_decode_seq

Sequential instruction fetch-and-decode engine that walks a programmable number of consecutive words in instruction memory starting at a parameterised base address. For each word it splits the MIPS-style 32-bit instruction into R/I/J format fields and presents them on a valid/ready output port. It sits between the `mem` instruction store and downstream consumers such as a decode monitor, trace logger or pipeline front end. It generalises the fixed 11-word, address-128 fetch-and-print loop into a parameterised, back-pressurable hardware block with configurable read latency.

## Interface
- `ADDR_W`, 32: width of the byte address.
- `BASE`, 128: byte address of the first fetched word.
- `STRIDE`, 4: byte increment between fetches.
- `MEM_LAT`, 1: cycles from `mem_read` assertion to valid `mem_data`; legal values are 0–3.
- `CNT_W`, 8: width of `count`.
- `JAL_IS_J`, 1: if 1, opcodes 2 and 3 both decode as J; if 0, only opcode 2 decodes as J.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled in IDLE only.
- `count` in CNT_W: number of words to fetch; latched on `start`.
- `mem_addr` out ADDR_W: word byte address presented to `mem`.
- `mem_read` out 1: read enable to `mem`.
- `mem_data` in 32: read data from `mem`.
- `out_valid` out 1: decoded word available.
- `out_ready` in 1: consumer accepts the word.
- `out_fmt` out 2: 0 = R, 1 = I, 2 = J; 3 is never driven.
- `out_addr` out ADDR_W: address of the presented word.
- `out_op` out 6: bits [31:26].
- `out_rs` out 5: bits [25:21].
- `out_rt` out 5: bits [20:16].
- `out_rd` out 5: bits [15:11].
- `out_shamt` out 5: bits [10:6].
- `out_funct` out 6: bits [5:0].
- `out_imm` out 16: bits [15:0].
- `out_target` out 26: bits [25:0].
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a run ends.

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, on `start` with `count` != 0: set `pc` to BASE and `remaining` to `count`, then go to ISSUE.
- IDLE, on `start` with `count` == 0: pulse `done` on the next cycle and stay in IDLE.
- ISSUE: drive `mem_read`=1 and `mem_addr`=`pc`.
  - If MEM_LAT == 0, sample `mem_data` in this cycle and go to HOLD.
  - Otherwise, go to WAIT.
- WAIT: hold `mem_read`=1 and `mem_addr`=`pc`, and count MEM_LAT−1 further cycles.
  - Sample `mem_data` in the last of those cycles, then go to HOLD.
  - For MEM_LAT == 1, WAIT lasts exactly 1 cycle.
- Sampling registers every field of the word, plus `out_addr`=`pc`.
- Format classification:
  - `op` == 0 → R.
  - `op` == 2, or `op` == 3 with JAL_IS_J=1 → J.
  - Anything else → I.
- All field outputs are driven regardless of format; the consumer uses `out_fmt` to select between them.
- HOLD: `out_valid`=1 and `mem_read`=0. All `out_*` signals stay stable until `out_ready`.
- On accept in HOLD (`out_valid` && `out_ready`):
  - `pc` ← `pc` + STRIDE, wrapping modulo 2^ADDR_W.
  - `remaining` ← `remaining` − 1.
  - If the new `remaining` is 0, pulse `done` and go to IDLE; otherwise go to ISSUE.
- `start` outside IDLE is ignored.
- `count` is only sampled on an accepted `start`.
- `reset` in any state forces IDLE on the next edge and aborts the run without a `done` pulse.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `out_valid`, `mem_read` all 0;
  - `mem_addr`, `out_addr`, `out_fmt` and all field outputs 0;
  - internal `pc`=0, `remaining`=0.
- `start` is sampled at edge e0. ISSUE occupies cycle e0+1 and `busy`=1 from e0+1.
- For a word whose ISSUE is cycle t, `out_valid` rises at t+MEM_LAT+1.
- With `out_ready` held high, the next ISSUE is at t+MEM_LAT+2, giving a period of MEM_LAT+2 cycles per word.
- Back-pressure stalls HOLD for any number of cycles with no loss or duplication of words.
- `done` is high in the cycle after the final accept. `busy`=0 in that same cycle, and a new `start` is accepted then.
- Outputs are registered; there is no combinational path from `out_ready` or `mem_data` to any output.

## Test plan
- Reset run: BASE=128, MEM_LAT=1, `count`=11, `out_ready`=1, memory preloaded with R, I and J words.
  - Addresses 128..168 step 4 appear in order.
  - `out_valid` pulses every 3 cycles.
  - `done` pulses once; exactly 11 accepts occur.
- Decode values:
  - 0x014B4820 → R: rs=10, rt=11, rd=9, funct=0x20.
  - 0x8D280004 → I: op=35, rs=9, rt=8, imm=4.
  - 0x08000020 → J: target=0x20.
  - 0x0C000020 → J when JAL_IS_J=1, I when JAL_IS_J=0.
- Back-pressure: `out_ready` random at 30% high.
  - `out_*` stable throughout each HOLD.
  - No `mem_read` during HOLD.
  - Accepted sequence identical to the no-stall run.
- Latency sweep: MEM_LAT in {0, 2, 3}.
  - `out_valid` at t+MEM_LAT+1.
  - Data captured matches the memory model delayed by MEM_LAT.
- Edge cases:
  - `count`=0 gives a `done` pulse with no `mem_read`.
  - BASE=0xFFFFFFFC with `count`=2 fetches 0xFFFFFFFC, then 0x00000000.
- Reset mid-run: assert `reset` in WAIT during the 3rd word.
  - Next cycle is IDLE with all outputs 0 and no `done`.
  - A fresh `start` restarts from BASE.
